// File: rtl/ysyx_23060184_xbar_if.sv
// Bus bundles for the memory crossbar: a read-only fetch port,
// a full read/write memory port and a write-only UART port.
interface ysyx_23060184_fetch_if #(
    parameter int DW = 32
);
    logic          valid;
    logic [DW-1:0] addr;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, addr,
        input  ready, rvalid, rdata
    );
    modport slave (
        input  valid, addr,
        output ready, rvalid, rdata
    );
endinterface

interface ysyx_23060184_xbar_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          wen;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, wen, addr, wdata, wmask,
        input  ready, rvalid, rdata
    );
    modport slave (
        input  valid, wen, addr, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

interface ysyx_23060184_uart_if;
    logic       valid;
    logic [7:0] wdata;
    logic       ready;

    modport master (
        output valid, wdata,
        input  ready
    );
    modport slave (
        input  valid, wdata,
        output ready
    );
endinterface

// File: rtl/ysyx_23060184_xbar.sv
// Single-outstanding crossbar: IFU/LSU masters to SRAM/UART slaves,
// path locked from grant capture until the response is returned.
module ysyx_23060184_xbar #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  grant,
    ysyx_23060184_fetch_if.slave        ifu,
    ysyx_23060184_xbar_if.slave         lsu,
    output logic                        lsu_err,
    ysyx_23060184_xbar_if.master        sram,
    ysyx_23060184_uart_if.master        uart
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SLV_REQ,
        S_SLV_RESP,
        S_RESP
    } state_e;

    localparam logic [1:0] G_IFU  = 2'b01;
    localparam logic [1:0] G_LSU  = 2'b10;
    localparam logic [1:0] G_UART = 2'b11;
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_e                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic       take_ifu;
    logic       take_lsu;
    logic       to_sram;
    logic       hs_sram;
    logic       hs_uart;
    logic [7:0] cnt_inc;
    logic       timed_out;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 4'h0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign take_ifu  = (grant == G_IFU) && ifu.valid;
    assign take_lsu  = grant[1] && lsu.valid;
    assign to_sram   = (sel_q == G_IFU) || (sel_q == G_LSU);
    assign hs_sram   = sram.valid && sram.ready;
    assign hs_uart   = uart.valid && uart.ready;
    assign cnt_inc   = cnt_q + 8'd1;
    assign timed_out = (cnt_inc == TO_LIM);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    take_ifu: begin
                        sel_d   = grant;
                        wen_d   = 1'b0;
                        addr_d  = ifu.addr;
                        wdata_d = '0;
                        wmask_d = 4'h0;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = S_ACCEPT;
                    end
                    take_lsu: begin
                        sel_d   = grant;
                        wen_d   = lsu.wen;
                        addr_d  = lsu.addr;
                        wdata_d = lsu.wdata;
                        wmask_d = lsu.wmask;
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = S_ACCEPT;
                    end
                    default: ;
                endcase
            end
            S_ACCEPT: begin
                cnt_d = 8'h00;
                // The UART has no read path: fail the access locally.
                if (sel_q == G_UART && !wen_q) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_SLV_REQ;
                end
            end
            S_SLV_REQ: begin
                cnt_d = cnt_inc;
                if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (sel_q == G_UART) begin
                    if (hs_uart) state_d = S_RESP;
                end else if (hs_sram) begin
                    state_d = S_SLV_RESP;
                end
            end
            S_SLV_RESP: begin
                cnt_d = cnt_inc;
                if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (sram.rvalid) begin
                    rdata_d = wen_q ? '0 : sram.rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ifu.ready  = (state_q == S_ACCEPT) && (sel_q == G_IFU);
    assign ifu.rvalid = (state_q == S_RESP) && (sel_q == G_IFU);
    assign ifu.rdata  = ifu.rvalid ? rdata_q : '0;

    assign lsu.ready  = (state_q == S_ACCEPT) && sel_q[1];
    assign lsu.rvalid = (state_q == S_RESP) && sel_q[1];
    assign lsu.rdata  = lsu.rvalid ? rdata_q : '0;
    assign lsu_err    = lsu.rvalid && err_q;

    assign sram.valid = (state_q == S_SLV_REQ) && to_sram;
    assign sram.wen   = wen_q;
    assign sram.addr  = addr_q;
    assign sram.wdata = wdata_q;
    assign sram.wmask = wmask_q;

    assign uart.valid = (state_q == S_SLV_REQ) && (sel_q == G_UART);
    assign uart.wdata = wdata_q[7:0];

endmodule

// File: tb/tb_ysyx_23060184_xbar.sv
// Bench for the crossbar: vector table plus lock and reset sequences,
// responses checked against a scoreboard queue.
module tb_ysyx_23060184_xbar;

    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] grant = 2'b00;
    logic       lsu_err;

    ysyx_23060184_fetch_if #(.DW(DW)) ifu ();
    ysyx_23060184_xbar_if  #(.DW(DW)) lsu ();
    ysyx_23060184_xbar_if  #(.DW(DW)) sram ();
    ysyx_23060184_uart_if             uart ();

    ysyx_23060184_xbar #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (8)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .grant  (grant),
        .ifu    (ifu),
        .lsu    (lsu),
        .lsu_err(lsu_err),
        .sram   (sram),
        .uart   (uart)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_ifu;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0]  grant;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          rdy;
        int          rv;
        logic        early;
        logic [31:0] rsp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_hs;
    } vec_t;

    // slave model knobs and captures
    int          rdy_dly = 0;
    int          rv_dly = 0;
    logic        early_rv = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    int          s_wait = 0;
    int          s_pend = -1;
    int          u_wait = 0;
    int          sram_hs = 0;
    int          uart_hs = 0;
    int          uart_seen = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wen;
    logic [3:0]  cap_wmask;
    logic [7:0]  cap_uart;

    always @(negedge clk) begin
        sram.ready  = 1'b0;
        sram.rvalid = 1'b0;
        sram.rdata  = 32'hBAD0_0000;
        if (s_pend == 0) begin
            sram.rvalid = 1'b1;
            sram.rdata  = rsp_data;
            s_pend      = -1;
        end else if (s_pend > 0) begin
            s_pend--;
        end
        if (sram.valid) begin
            if (s_wait >= rdy_dly) begin
                sram.ready = 1'b1;
                s_wait     = 0;
                s_pend     = rv_dly;
                sram_hs++;
                cap_addr   = sram.addr;
                cap_wdata  = sram.wdata;
                cap_wen    = sram.wen;
                cap_wmask  = sram.wmask;
                if (early_rv) begin
                    sram.rvalid = 1'b1;
                    sram.rdata  = 32'hDEAD_DEAD;
                end
            end else begin
                s_wait++;
            end
        end else begin
            s_wait = 0;
        end
    end

    always @(negedge clk) begin
        uart.ready = 1'b0;
        if (uart.valid) begin
            uart_seen++;
            if (u_wait >= rdy_dly) begin
                uart.ready = 1'b1;
                u_wait     = 0;
                cap_uart   = uart.wdata;
                uart_hs++;
            end else begin
                u_wait++;
            end
        end else begin
            u_wait = 0;
        end
    end

    logic        pv_s = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [4:0]  p_ctl;
    logic        pv_u = 1'b0;
    logic [7:0]  p_uw;
    logic        p_ir = 1'b0, p_iv = 1'b0, p_lr = 1'b0, p_lv = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (ifu.rvalid || lsu.rvalid) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: ifu_rvalid %b lsu_rvalid %b with empty queue",
                             ifu.rvalid, lsu.rvalid);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", {31'b0, ifu.rvalid}, {31'b0, e.is_ifu});
                    if (e.is_ifu) chk("ifu_rdata", ifu.rdata, e.rdata);
                    else begin
                        chk("lsu_rdata", lsu.rdata, e.rdata);
                        chk("lsu_err", {31'b0, lsu_err}, {31'b0, e.err});
                    end
                end
            end
            if (ifu.ready) chk("ifu_ready_pulse", {31'b0, p_ir | ifu.rvalid}, 0);
            if (ifu.rvalid) chk("ifu_rvalid_pulse", {31'b0, p_iv}, 0);
            if (lsu.ready) chk("lsu_ready_pulse", {31'b0, p_lr | lsu.rvalid}, 0);
            if (lsu.rvalid) chk("lsu_rvalid_pulse", {31'b0, p_lv}, 0);
            if (sram.valid && pv_s) begin
                chk("sram_addr_stable", sram.addr, p_addr);
                chk("sram_wdata_stable", sram.wdata, p_wdata);
                chk("sram_ctl_stable", {27'b0, sram.wen, sram.wmask}, {27'b0, p_ctl});
            end
            if (uart.valid && pv_u) chk("uart_wdata_stable", {24'b0, uart.wdata}, {24'b0, p_uw});
            pv_s    = sram.valid;
            p_addr  = sram.addr;
            p_wdata = sram.wdata;
            p_ctl   = {sram.wen, sram.wmask};
            pv_u    = uart.valid;
            p_uw    = uart.wdata;
            p_ir    = ifu.ready;
            p_iv    = ifu.rvalid;
            p_lr    = lsu.ready;
            p_lv    = lsu.rvalid;
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {25'b0, ifu.ready, ifu.rvalid, lsu.ready, lsu.rvalid,
                            lsu_err, sram.valid, uart.valid}, 0);
        chk({tag, "_sram_addr"}, sram.addr, 0);
        chk({tag, "_sram_wdata"}, sram.wdata, 0);
        chk({tag, "_sram_ctl"}, {27'b0, sram.wen, sram.wmask}, 0);
        chk({tag, "_rdata"}, ifu.rdata | lsu.rdata | {24'b0, uart.wdata}, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   hs0 = sram_hs;
        int   uh0 = uart_hs;
        int   us0 = uart_seen;
        int   lat = 0;
        logic is_ifu = (v.grant == 2'b01);
        @(negedge clk);
        rdy_dly  = v.rdy;
        rv_dly   = v.rv;
        early_rv = v.early;
        rsp_data = v.rsp;
        grant    = v.grant;
        if (is_ifu) begin
            ifu.valid = 1'b1;
            ifu.addr  = v.addr;
            lsu.wen   = 1'b1;
            lsu.wdata = 32'hFFFF_FFFF;
            lsu.wmask = 4'hF;
        end else begin
            lsu.valid = 1'b1;
            lsu.wen   = v.wen;
            lsu.addr  = v.addr;
            lsu.wdata = v.wdata;
            lsu.wmask = v.wmask;
        end
        sbq.push_back('{is_ifu, v.exp_rdata, v.exp_err});
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk($sformatf("v%0d_ready", idx),
                    {31'b0, is_ifu ? ifu.ready : lsu.ready}, 1);
                ifu.valid = 1'b0;
                lsu.valid = 1'b0;
                grant     = 2'b00;
            end
            if (is_ifu ? ifu.rvalid : lsu.rvalid) lat = k;
        end
        if (lat == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL v%0d_rsp_timeout: got no response expected one within 40 cycles", idx);
        end else begin
            chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        end
        chk($sformatf("v%0d_sram_hs", idx), sram_hs - hs0, (v.exp_hs == 1) ? 1 : 0);
        chk($sformatf("v%0d_uart_hs", idx), uart_hs - uh0, (v.exp_hs == 2) ? 1 : 0);
        chk($sformatf("v%0d_uart_seen", idx), {31'b0, uart_seen != us0},
            {31'b0, v.grant == 2'b11 && v.wen});
        if (v.exp_hs == 1) begin
            chk($sformatf("v%0d_cap_addr", idx), cap_addr, v.addr);
            chk($sformatf("v%0d_cap_ctl", idx), {27'b0, cap_wen, cap_wmask},
                is_ifu ? 0 : {27'b0, v.wen, v.wmask});
            if (v.wen && !is_ifu) chk($sformatf("v%0d_cap_wdata", idx), cap_wdata, v.wdata);
        end
        if (v.exp_hs == 2) chk($sformatf("v%0d_cap_uart", idx), {24'b0, cap_uart},
                               {24'b0, v.wdata[7:0]});
        repeat (25) @(negedge clk);
    endtask

    vec_t tbl[11];

    initial begin
        int ifu_rv_k = 0, lsu_rdy_k = 0, lsu_rv_k = 0;
        ifu.valid = 1'b0;
        ifu.addr  = 32'h0;
        lsu.valid = 1'b0;
        lsu.wen   = 1'b0;
        lsu.addr  = 32'h0;
        lsu.wdata = 32'h0;
        lsu.wmask = 4'h0;

        tbl[0]  = '{2'b01, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 1'b0,
                    32'h0000_0413, 32'h0000_0413, 1'b0, 4, 1};
        tbl[1]  = '{2'b10, 1'b1, 32'h8000_1000, 32'hCAFE_BABE, 4'hF, 3, 0, 1'b0,
                    32'h1111_1111, 32'h0, 1'b0, 7, 1};
        tbl[2]  = '{2'b10, 1'b0, 32'h8000_2004, 32'h0, 4'h0, 0, 2, 1'b0,
                    32'h1234_5678, 32'h1234_5678, 1'b0, 6, 1};
        tbl[3]  = '{2'b10, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 0, 1'b1,
                    32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 5, 1};
        tbl[4]  = '{2'b11, 1'b1, 32'h1000_0000, 32'h0000_0041, 4'h1, 2, 0, 1'b0,
                    32'h0, 32'h0, 1'b0, 5, 2};
        tbl[5]  = '{2'b11, 1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, 0, 1'b0,
                    32'h0, 32'h0, 1'b1, 2, 0};
        tbl[6]  = '{2'b10, 1'b0, 32'h8000_0100, 32'h0, 4'h0, 100, 0, 1'b0,
                    32'h9999_9999, 32'h0, 1'b1, 10, 0};
        tbl[7]  = '{2'b01, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 100, 0, 1'b0,
                    32'h9999_9999, 32'h0, 1'b0, 10, 0};
        tbl[8]  = '{2'b10, 1'b1, 32'h8000_0300, 32'h0BAD_0BAD, 4'h3, 0, 20, 1'b0,
                    32'h7777_7777, 32'h0, 1'b1, 10, 1};
        tbl[9]  = '{2'b11, 1'b1, 32'h1000_0000, 32'h0000_005A, 4'h1, 100, 0, 1'b0,
                    32'h0, 32'h0, 1'b1, 10, 0};
        tbl[10] = '{2'b10, 1'b0, 32'h8000_0400, 32'h0, 4'h0, 5, 0, 1'b0,
                    32'h0600_D0D0, 32'h0600_D0D0, 1'b0, 9, 1};

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // path lock: LSU requests while the IFU fetch waits in SLV_RESP
        @(negedge clk);
        rdy_dly   = 0;
        rv_dly    = 3;
        early_rv  = 1'b0;
        rsp_data  = 32'h0000_0013;
        grant     = 2'b01;
        ifu.valid = 1'b1;
        ifu.addr  = 32'h8000_0004;
        sbq.push_back('{1'b1, 32'h0000_0013, 1'b0});
        for (int k = 1; k <= 40 && lsu_rv_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) ifu.valid = 1'b0;
            if (k == 3) begin
                grant     = 2'b10;
                lsu.valid = 1'b1;
                lsu.wen   = 1'b0;
                lsu.addr  = 32'h8000_3000;
                sbq.push_back('{1'b0, 32'h0000_0013, 1'b0});
            end
            if (ifu.rvalid) begin
                ifu_rv_k = k;
                rv_dly   = 0;
            end
            if (lsu.ready && lsu_rdy_k == 0) begin
                lsu_rdy_k = k;
                lsu.valid = 1'b0;
                grant     = 2'b00;
            end
            if (lsu.rvalid) lsu_rv_k = k;
        end
        chk("lock_ifu_rvalid_cycle", ifu_rv_k, 7);
        chk("lock_lsu_ready_cycle", lsu_rdy_k, 9);
        chk("lock_lsu_rvalid_cycle", lsu_rv_k, 12);
        repeat (10) @(negedge clk);

        // reset while a write waits in SLV_REQ
        @(negedge clk);
        rdy_dly   = 100;
        grant     = 2'b10;
        lsu.valid = 1'b1;
        lsu.wen   = 1'b1;
        lsu.addr  = 32'h8000_4000;
        lsu.wdata = 32'h5555_AAAA;
        lsu.wmask = 4'hF;
        @(negedge clk);
        lsu.valid = 1'b0;
        grant     = 2'b00;
        @(negedge clk);
        chk("rst_pre_sram_valid", {31'b0, sram.valid}, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk_quiet("midreset");
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_post_sram_valid", {31'b0, sram.valid}, 0);
        run_vec(tbl[2], 2);

        chk("queue_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
